// File: rtl/pipe_result_queue.sv
// Multi-lane result pipeline: carries issued results to writeback, captures late
// results at one stage, and forwards the youngest matching result to query ports.
module pipe_result_queue #(
    parameter int ISSUE_NUM   = 2,
    parameter int DEPTH       = 3,
    parameter int LATE_STAGE  = 2,
    parameter int QUERY_PORTS = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ISSUE_NUM-1:0]  kill_mask,
    input  logic [ISSUE_NUM-1:0]  in_valid,
    input  logic [4:0]            in_rd      [ISSUE_NUM],
    input  logic [DATA_WIDTH-1:0] in_wdata   [ISSUE_NUM],
    input  logic [ISSUE_NUM-1:0]  in_late,
    input  logic [DATA_WIDTH-1:0] late_wdata [ISSUE_NUM],
    input  logic [4:0]            q_raddr    [QUERY_PORTS],
    output logic [QUERY_PORTS-1:0] q_hit,
    output logic [QUERY_PORTS-1:0] q_pend,
    output logic [DATA_WIDTH-1:0] q_data     [QUERY_PORTS],
    output logic [ISSUE_NUM-1:0]  out_we,
    output logic [4:0]            out_rd     [ISSUE_NUM],
    output logic [DATA_WIDTH-1:0] out_wdata  [ISSUE_NUM],
    output logic                  busy
);

    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_result_queue: DEPTH must be within 2..8");
    end
    if (LATE_STAGE < 1 || LATE_STAGE > DEPTH - 1) begin : g_bad_late
        $error("pipe_result_queue: LATE_STAGE must be within 1..DEPTH-1");
    end

    logic [ISSUE_NUM-1:0]  st_valid [DEPTH];
    logic [ISSUE_NUM-1:0]  st_late  [DEPTH];
    logic [4:0]            st_rd    [DEPTH][ISSUE_NUM];
    logic [DATA_WIDTH-1:0] st_wdata [DEPTH][ISSUE_NUM];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                st_valid[s] <= '0;
                st_late[s]  <= '0;
                for (int l = 0; l < ISSUE_NUM; l++) begin
                    st_rd[s][l]    <= '0;
                    st_wdata[s][l] <= '0;
                end
            end
        end else if (!stall) begin
            for (int l = 0; l < ISSUE_NUM; l++) begin
                st_valid[0][l] <= in_valid[l] & ~kill_mask[l];
                st_late[0][l]  <= in_late[l] & ~kill_mask[l];
                st_rd[0][l]    <= kill_mask[l] ? 5'd0 : in_rd[l];
                st_wdata[0][l] <= kill_mask[l] ? '0 : in_wdata[l];
            end
            for (int s = 1; s < DEPTH; s++) begin
                for (int l = 0; l < ISSUE_NUM; l++) begin
                    st_valid[s][l] <= st_valid[s-1][l];
                    st_rd[s][l]    <= st_rd[s-1][l];
                    // late results arrive alongside the entry moving into LATE_STAGE
                    if (s == LATE_STAGE && st_late[s-1][l]) begin
                        st_wdata[s][l] <= late_wdata[l];
                        st_late[s][l]  <= 1'b0;
                    end else begin
                        st_wdata[s][l] <= st_wdata[s-1][l];
                        st_late[s][l]  <= st_late[s-1][l];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < ISSUE_NUM; l++) begin
            out_we[l]    = st_valid[DEPTH-1][l] && (st_rd[DEPTH-1][l] != 5'd0) && !stall;
            out_rd[l]    = st_rd[DEPTH-1][l];
            out_wdata[l] = st_wdata[DEPTH-1][l];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            busy = busy | (|st_valid[s]);
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        for (int p = 0; p < QUERY_PORTS; p++) begin
            q_hit[p]  = 1'b0;
            q_pend[p] = 1'b0;
            q_data[p] = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = 0; l < ISSUE_NUM; l++) begin
                    if (st_valid[s][l] && (q_raddr[p] != 5'd0) && (st_rd[s][l] == q_raddr[p])) begin
                        q_hit[p]  = 1'b1;
                        q_pend[p] = st_late[s][l];
                        q_data[p] = st_late[s][l] ? '0 : st_wdata[s][l];
                    end
                end
            end
        end
    end

endmodule
